// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: the decode payload and the NOP filler word.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory and decode handshake bundle of the fetch stage.
interface fetch_buffer_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             imem_req_o;
    logic [WIDTH-1:0] imem_addr_o;
    logic             imem_gnt_i;
    logic             imem_rvalid_i;
    logic [WIDTH-1:0] imem_rdata_i;
    logic             dec_valid_o;
    logic             dec_ready_i;
    logic [WIDTH-1:0] dec_instr_o;
    logic [WIDTH-1:0] dec_pc_o;

    modport master (
        output imem_req_o, imem_addr_o, dec_valid_o, dec_instr_o, dec_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, dec_valid_o, dec_instr_o, dec_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous clear; pointers wrap modulo DEPTH, count is one bit wider.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = ptr_inc(wptr_q);
            if (do_pop)  rptr_d = ptr_inc(rptr_q);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (rst_n && !clr_i && do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: credit-limited in-order imem requests, PC/instr pairing, decode FIFO, redirect discard.
// Optional FETCH_BYPASS_EN: zero-latency response bypass onto decode when the FIFO is empty.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             flush_i,
    output logic             stall_o,
    fetch_buffer_if.master   bus
);
    localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned SUM_W  = ((FCNT_W > OCNT_W) ? FCNT_W : OCNT_W) + 1;

    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      fifo_head;
    fetch_entry_t      new_entry;
    fetch_entry_t      head;

    logic [OCNT_W-1:0] out_cnt;
    logic              pend_empty;
    logic [WIDTH-1:0]  pend_pc;

    logic [OCNT_W-1:0] disc_q, disc_d;
    logic [OCNT_W-1:0] live_cnt;
    logic [SUM_W-1:0]  credit_sum;
    logic              req;
    logic              accept;
    logic              resp;
    logic              discarding;
    logic              bypass;
    logic              dec_valid;

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_entry_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush_i),
        .push_i  (fifo_push),
        .wdata_i (new_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    // Pending-PC queue: its occupancy is the outstanding-request count.
    sync_fifo #(.WIDTH(WIDTH), .DEPTH(MAX_OUTSTANDING)) u_pend_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (1'b0),
        .push_i  (accept),
        .wdata_i (pc_i),
        .pop_i   (resp),
        .rdata_o (pend_pc),
        .count_o (out_cnt),
        .empty_o (pend_empty)
    );

    always_comb begin
        resp       = bus.imem_rvalid_i && !pend_empty;
        discarding = (disc_q != '0);
        live_cnt   = out_cnt - disc_q;
        credit_sum = SUM_W'(fifo_cnt) + SUM_W'(live_cnt);
        req        = rst_n && !flush_i
                     && (out_cnt < OCNT_W'(MAX_OUTSTANDING))
                     && (credit_sum < SUM_W'(DEPTH));
        accept     = req && bus.imem_gnt_i;

        new_entry.instr = XLEN'(bus.imem_rdata_i);
        new_entry.pc    = XLEN'(pend_pc);

`ifdef FETCH_BYPASS_EN
        bypass = fifo_empty && !flush_i && resp && !discarding;
`else
        bypass = 1'b0;
`endif
        head      = bypass ? new_entry : fifo_head;
        dec_valid = rst_n && (!fifo_empty || bypass);
        fifo_push = resp && !discarding && !flush_i && !(bypass && bus.dec_ready_i);
        fifo_pop  = !fifo_empty && bus.dec_ready_i && !flush_i;
    end

    // Redirect: every request still in flight after this cycle is dropped on return.
    always_comb begin
        disc_d = disc_q;
        if (flush_i) begin
            disc_d = out_cnt - OCNT_W'(resp);
        end else if (resp && discarding) begin
            disc_d = disc_q - OCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) disc_q <= '0;
        else        disc_q <= disc_d;
    end

    always_comb begin
        stall_o         = rst_n && !accept;
        bus.imem_req_o  = req;
        bus.imem_addr_o = rst_n ? pc_i : '0;
        bus.dec_valid_o = dec_valid;
        bus.dec_instr_o = '0;
        bus.dec_pc_o    = '0;
        if (dec_valid) begin
            bus.dec_instr_o = WIDTH'(head.instr);
            bus.dec_pc_o    = WIDTH'(head.pc);
        end else if (rst_n) begin
            bus.dec_instr_o = WIDTH'(NOP_INSTR);
        end
    end

    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rvalid_i |-> !pend_empty);

    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_cnt <= FCNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a PC model and memory model feed the DUT, a monitor checks decode.
module tb_fetch_buffer;

    localparam int unsigned W = 32;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pc_i;
    logic         flush_i;
    logic         stall_o;

    fetch_buffer_if #(.WIDTH(W)) bus ();

    fetch_buffer #(.WIDTH(W), .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc_i    (pc_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned due; logic [W-1:0] addr; } mreq_t;
    typedef struct { logic [W-1:0] pc; logic [W-1:0] instr; } want_t;

    mreq_t        mem_q[$];
    want_t        want_q[$];
    int unsigned  cyc;
    int unsigned  lat;
    logic [W-1:0] pc_nxt;
    logic [W-1:0] flush_tgt;
    logic         chk_first;
    int           n_vec;
    int           n_err;

    function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Advance one cycle: PC register update and in-order memory response.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        pc_i = rst_n ? pc_nxt : 32'h40;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
    endtask

    // Program counter and memory accept model; expected decode stream is pushed on accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            pc_nxt = '0;
        end else if (flush_i) begin
            pc_nxt = flush_tgt;
            want_q.delete();
            chk_first = 1'b1;
        end else begin
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                mem_q.push_back('{cyc + lat, bus.imem_addr_o});
                want_q.push_back('{pc_i, instr_of(pc_i)});
            end
            pc_nxt = stall_o ? pc_i : pc_i + 32'd4;
        end
    end

    // Monitor: every decode handshake pops one expected pair.
    always @(negedge clk) begin : mon
        want_t e;
        if (rst_n && bus.dec_valid_o && bus.dec_ready_i) begin
            if (want_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dec_unexpected: got pc %h, expected no entry", bus.dec_pc_o);
            end else begin
                e = want_q.pop_front();
                check("dec_pc", bus.dec_pc_o, e.pc);
                check("dec_instr", bus.dec_instr_o, e.instr);
                if (chk_first) begin
                    check("first_after_flush", bus.dec_pc_o, 32'h100);
                    chk_first = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; pc_i = 32'h40; flush_i = 1'b0; flush_tgt = 32'h100;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        bus.dec_ready_i = 1'b0;
        lat = 1; cyc = 0; n_vec = 0; n_err = 0; chk_first = 1'b0; pc_nxt = '0;

        // Reset: all outputs low, PC ignored
        repeat (3) tick();
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(bus.imem_req_o), 32'd0);
        check("rst_valid", 32'(bus.dec_valid_o), 32'd0);
        check("rst_addr", bus.imem_addr_o, 32'h0);
        check("rst_instr", bus.dec_instr_o, 32'h0);

        rst_n = 1'b1; pc_i = 32'h0;
        bus.imem_gnt_i = 1'b1; bus.dec_ready_i = 1'b1;
        #1;
        check("first_req", 32'(bus.imem_req_o), 32'd1);
        check("first_addr", bus.imem_addr_o, 32'h0);
        check("first_stall", 32'(stall_o), 32'd0);
        check("idle_nop", bus.dec_instr_o, 32'h13);

        // Streaming: one fetch per cycle
        for (int i = 0; i < 12; i++) begin
            tick();
            #1;
            if (i >= 3) begin
                check("stream_stall", 32'(stall_o), 32'd0);
                check("stream_valid", 32'(bus.dec_valid_o), 32'd1);
            end
        end

        // Grant stall: PC 0x34 held for 3 cycles
        tick();
        bus.imem_gnt_i = 1'b0;
        #1;
        check("gnt_stall", 32'(stall_o), 32'd1);
        check("gnt_addr", bus.imem_addr_o, 32'h34);
        repeat (2) begin
            tick();
            #1;
            check("gnt_stall", 32'(stall_o), 32'd1);
            check("gnt_addr", bus.imem_addr_o, 32'h34);
        end

        // Backpressure: decode blocked, occupancy capped at DEPTH
        tick();
        bus.imem_gnt_i = 1'b1;
        bus.dec_ready_i = 1'b0;
        repeat (9) tick();
        #1;
        check("bp_stall", 32'(stall_o), 32'd1);
        check("bp_valid", 32'(bus.dec_valid_o), 32'd1);
        check("bp_fill", 32'(want_q.size()), 32'd4);
        bus.dec_ready_i = 1'b1;
        repeat (8) tick();

        // Redirect with requests in flight
        lat = 3;
        repeat (6) tick();
        bus.dec_ready_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check("flush_req", 32'(bus.imem_req_o), 32'd0);
        tick();
        flush_i = 1'b0;
        bus.dec_ready_i = 1'b1;
        #1;
        check("flush_empty", 32'(bus.dec_valid_o), 32'd0);
        lat = 1;
        repeat (8) tick();

        // Drain everything
        bus.imem_gnt_i = 1'b0;
        k = 0;
        while ((want_q.size() != 0 || mem_q.size() != 0) && k < 40) begin
            tick();
            k++;
        end
        check("drain_bounded", 32'(k < 40), 32'd1);
        check("flush_target_seen", 32'(chk_first), 32'd0);

        // Empty FIFO response latency
        tick();
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        #1;
        check("resp_rvalid", 32'(bus.imem_rvalid_i), 32'd1);
        check("resp_same_cycle", 32'(bus.dec_valid_o), 32'(BYP));
        tick();
        #1;
        check("resp_next_cycle", 32'(bus.dec_valid_o), 32'(!BYP));
        repeat (3) tick();
        check("end_empty", 32'(want_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage directly downstream of program_counter.
- Each cycle it takes the current PC and issues an in-order request to instruction memory.
- It tracks outstanding requests, pairs each returned word with its PC, and buffers the pairs in a FIFO for decode (valid/ready).
- It drives stall back to program_counter on backpressure and discards in-flight fetches on a branch/jump/RET redirect.

Parameters:
WIDTH, 32, PC/address and instruction width
DEPTH, 4, fetch FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max accepted-but-unreturned memory requests (power of 2, >=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
pc_i  in  WIDTH  current PC from program_counter
flush_i  in  1  redirect this cycle (PCsrc != 2'b00); younger fetches are discarded
stall_o  out  1  to program_counter: current pc_i not accepted, hold PC
imem_req_o  out  1  memory request valid
imem_addr_o  out  WIDTH  request address (= pc_i)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid, in request order, >=1 cycle after grant
imem_rdata_i  in  WIDTH  response instruction
dec_valid_o  out  1  FIFO head valid
dec_ready_i  in  1  decode accepts head
dec_instr_o  out  WIDTH  head instruction
dec_pc_o  out  WIDTH  head PC

Behaviour:
- Reset (rst_n=0 at posedge): clear FIFO, pending-PC queue, outstanding count and discard count.
- While rst_n=0, all outputs are 0. stall_o must be 0 so program_counter's own reset can take effect.
- Credit rule: imem_req_o = !flush_i && outstanding < MAX_OUTSTANDING && (fifo_count + outstanding_live) < DEPTH.
  - outstanding_live = outstanding - discard_count.
  - fifo_count used here is the registered value; no same-cycle credit from a pop.
- imem_addr_o = pc_i combinationally.
- Accept: imem_req_o && imem_gnt_i. pc_i is pushed into the pending-PC queue and outstanding increments.
- stall_o = rst_n && !(imem_req_o && imem_gnt_i). On flush, program_counter loads the target regardless, because a redirect is not gated by this stall.
- Response: imem_rvalid_i pops the pending-PC queue and outstanding decrements.
  - If discard_count>0: drop the response and decrement discard_count.
  - Otherwise push {imem_rdata_i, popped PC} into the FIFO.
- rvalid with outstanding==0 is a protocol error: ignore it; assertion in simulation.
- Decode: dec_valid_o = FIFO not empty. Head pops on dec_valid_o && dec_ready_i. Push and pop in the same cycle keep the count unchanged.
- Registered path: a response reaches dec_valid_o 1 cycle after rvalid.
- Flush (priority over everything except reset):
  - FIFO is emptied at the next edge, so dec_valid_o=0 next cycle.
  - discard_count <= outstanding after this cycle's accept/response.
  - No request this cycle.
  - A response arriving in the flush cycle counts as discarded.
- FIFO overflow cannot occur by the credit rule; assert fifo_count<=DEPTH.
- Pointers wrap modulo DEPTH and MAX_OUTSTANDING. Counters are one bit wider than their pointers.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, no flush is active and imem_rvalid_i is high with nothing to discard, the response is driven combinationally onto dec_valid_o/dec_instr_o/dec_pc_o (0-cycle latency).
  - If dec_ready_i is also high, the entry is not written to the FIFO.
- Undefined: the registered 1-cycle path only.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t {instr, pc}
  - localparam NOP_INSTR = 32'h00000013, driven on dec_instr_o when invalid
- One natural sub-module, sync_fifo (parameterised width/depth, synchronous clear). It is instantiated twice: the entry FIFO and the pending-PC queue.

Test Plan:
- Reset: rst_n=0 with pc_i=0x40 -> stall_o=0, imem_req_o=0, dec_valid_o=0. First cycle after release, req with addr=0x00.
- Streaming: gnt=1 every cycle, 1-cycle response latency, dec_ready=1 -> PCs 0x0, 0x4, 0x8… appear on dec_pc_o in order with matching instr, one per cycle, stall_o=0.
- Backpressure: dec_ready=0 for 10 cycles -> FIFO holds exactly DEPTH=4 entries and stall_o=1. PC is held with no lost or duplicated PC after dec_ready returns.
- Flush with 2 outstanding (PCs 0x10, 0x14): flush_i=1 -> both responses dropped, FIFO empty next cycle. First delivered PC is the redirect target, e.g. 0x100.
- Grant stall: gnt=0 for 3 cycles -> stall_o=1 for those cycles and imem_addr_o stable at the held PC.
- FETCH_BYPASS_EN: empty FIFO, rvalid with dec_ready=1 -> dec_valid_o is high in the same cycle and fifo_count stays 0. Without the macro, dec_valid_o rises 1 cycle later.
